// File: rtl/hello_world_demo_pio_pkg.sv
// Shared register map and edge-mode encodings for the hello_world_demo PIO blocks.
package hello_world_demo_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RESERVED = 2'd1,
    ADDR_MASK     = 2'd2,
    ADDR_EDGE     = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic edge_hit(input int mode, input logic cur, input logic prev);
    case (mode)
      EDGE_RISING:  return cur & ~prev;
      EDGE_FALLING: return ~cur & prev;
      default:      return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/hello_world_demo_button_debounce.sv
// One button bit: 2-flop synchronizer, 3-sample history on the shared tick, debounced output.
module hello_world_demo_button_debounce (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic din,
  output logic dout
);

  logic [1:0] sync;
  logic [2:0] hist;
  logic [2:0] hist_next;

  assign hist_next = {hist[1:0], sync[1]};

  // The output only follows the samples once three consecutive ones agree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      hist <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (tick) begin
        hist <= hist_next;
        if (hist_next == 3'b000 || hist_next == 3'b111) begin
          dout <= hist_next[0];
        end
      end
    end
  end

endmodule

// File: rtl/hello_world_demo_button_pio.sv
// Avalon-MM button PIO: debounced inputs, edge capture with W1C, maskable level interrupt.
module hello_world_demo_button_pio
  import hello_world_demo_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0]    presc;
  logic             tick;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] rd_mux;
  logic             wr;

  assign tick = (presc == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + CW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    hello_world_demo_button_debounce u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .din     (in_port[i]),
      .dout    (deb[i])
    );
  end

  assign wr       = chipselect & ~write_n;
  assign edge_clr = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    edge_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_set[i] = edge_hit(EDGE_TYPE, deb[i], deb_q[i]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (pio_addr_e'(address))
      ADDR_DATA: rd_mux = deb;
      ADDR_MASK: rd_mux = mask;
      ADDR_EDGE: rd_mux = capture;
      default:   rd_mux = '0;
    endcase
  end

  // A new edge is OR-ed in after the clear, so a simultaneous set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q    <= '0;
      capture  <= '0;
      mask     <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      deb_q    <= deb;
      capture  <= (capture & ~edge_clr) | edge_set;
      if (wr && address == ADDR_MASK) begin
        mask <= writedata[WIDTH-1:0];
      end
      readdata <= 32'(rd_mux);
      irq      <= |(capture & mask);
    end
  end

  if (WIDTH < 32) begin : g_wdata_upper
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_hello_world_demo_button_pio.sv
// Self-checking bench: directed register-map scenarios plus random traffic against a sample-window model.
module tb_hello_world_demo_button_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hello_world_demo_button_pio #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .EDGE_TYPE       (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Reference: every D-th cycle takes the input seen two cycles earlier as a sample;
  // a bit becomes 1 when its last three samples are all 1 and 0 when all are 0.
  int           n = 0;
  int           ones;
  logic [W-1:0] in_q[$];
  logic [W-1:0] samp_q[$];
  logic [W-1:0] m_deb  = '0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_cap  = '0;
  logic [W-1:0] m_mask = '0;
  logic [W-1:0] m_clr  = '0;
  logic [W-1:0] m_samp = '0;
  logic [31:0]  m_rd   = '0;
  logic         m_irq  = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n = 0;
      in_q.delete();
      samp_q.delete();
      m_deb  = '0;
      m_pend = '0;
      m_cap  = '0;
      m_mask = '0;
      m_rd   = '0;
      m_irq  = 1'b0;
    end else begin
      n = n + 1;
      in_q.push_back(in_port);
      case (address)
        2'd0:    m_rd = 32'(m_deb);
        2'd2:    m_rd = 32'(m_mask);
        2'd3:    m_rd = 32'(m_cap);
        default: m_rd = 32'd0;
      endcase
      m_irq = |(m_cap & m_mask);
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_cap  = (m_cap & ~m_clr) | m_pend;
      m_pend = '0;
      if (n % D == 0) begin
        m_samp = (n >= 3) ? in_q[n-3] : '0;
        samp_q.push_back(m_samp);
        for (int b = 0; b < W; b++) begin
          ones = 0;
          for (int k = 0; k < 3; k++) begin
            if (samp_q.size() > k && samp_q[samp_q.size()-1-k][b]) ones++;
          end
          if (ones == 3 && !m_deb[b]) begin
            m_deb[b]  = 1'b1;
            m_pend[b] = 1'b1;
          end else if (ones == 0) begin
            m_deb[b] = 1'b0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput("model_readdata", readdata, m_rd);
    checkOutput("model_irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic wn,
                               input logic [31:0] wd, input logic [W-1:0] inp, input int cycles);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = inp;
    for (int c = 0; c < cycles; c++) stepCycle();
  endtask

  initial begin
    bit found;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    $display("[TB] reset released");

    applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, 4'h0, 3);
    applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, 4'h1, 20);
    checkOutput("held_input_data", readdata, 32'h1);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'h1, 2);
    checkOutput("held_input_edge", readdata, 32'h1);

    applyStimulus(2'd3, 1'b1, 1'b0, 32'hF, 4'h1, 1);
    applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, 4'h0, 20);
    checkOutput("release_data", readdata, 32'h0);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'h0, 2);
    checkOutput("falling_not_captured", readdata, 32'h0);

    for (int c = 0; c < 40; c++) begin
      applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, ((c / 3) % 2 == 1) ? 4'h1 : 4'h0, 1);
    end
    checkOutput("bounce_data", readdata, 32'h0);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'h0, 2);
    checkOutput("bounce_edge", readdata, 32'h0);

    applyStimulus(2'd2, 1'b1, 1'b0, 32'h1, 4'h0, 1);
    applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, 4'h1, 20);
    checkOutput("mask_irq_set", {31'd0, irq}, 32'h1);
    applyStimulus(2'd3, 1'b1, 1'b0, 32'h1, 4'h1, 1);
    checkOutput("w1c_irq_hold", {31'd0, irq}, 32'h1);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'h1, 1);
    checkOutput("w1c_irq_clear", {31'd0, irq}, 32'h0);
    checkOutput("w1c_edge_clear", readdata, 32'h0);

    applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, 4'h0, 20);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, 4'h1, 1);
      if (m_pend[0]) found = 1'b1;
    end
    checkOutput("edge_arrival_seen", {31'd0, found}, 32'h1);
    applyStimulus(2'd3, 1'b1, 1'b0, 32'h1, 4'h1, 1);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'h1, 2);
    checkOutput("set_beats_clear", readdata, 32'h1);

    applyStimulus(2'd2, 1'b1, 1'b0, 32'h0, 4'h1, 1);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'hF, 20);
    checkOutput("all_captured", readdata, 32'hF);
    checkOutput("masked_irq", {31'd0, irq}, 32'h0);
    applyStimulus(2'd2, 1'b1, 1'b0, 32'hFFFF_FFF8, 4'hF, 1);
    checkOutput("mask8_same_cycle", {31'd0, irq}, 32'h0);
    applyStimulus(2'd2, 1'b1, 1'b1, 32'h0, 4'hF, 1);
    checkOutput("mask8_irq", {31'd0, irq}, 32'h1);
    checkOutput("mask_upper_ignored", readdata, 32'h8);
    applyStimulus(2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'hF, 1);
    applyStimulus(2'd1, 1'b1, 1'b1, 32'h0, 4'hF, 1);
    checkOutput("addr1_reads_zero", readdata, 32'h0);

    applyStimulus(2'd2, 1'b1, 1'b0, 32'hF, 4'hF, 1);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'h0, 20);
    checkOutput("pre_reset_irq", {31'd0, irq}, 32'h1);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'hF, 6);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_readdata", readdata, 32'h0);
    checkOutput("async_reset_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, 4'hF, 8);
    checkOutput("redebounce_not_early", readdata, 32'h0);
    applyStimulus(2'd0, 1'b1, 1'b1, 32'h0, 4'hF, 12);
    checkOutput("redebounce_data", readdata, 32'hF);
    applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, 4'hF, 2);
    checkOutput("redebounce_edge", readdata, 32'hF);

    for (int seg = 0; seg < 30; seg++) begin
      logic [W-1:0] inp;
      int len;
      inp = W'($urandom);
      len = $urandom_range(1, 25);
      for (int c = 0; c < len; c++) begin
        applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0), $urandom, inp, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
